rf_wb_arbiter: RTL and testbench

Sequences the single register-file write port (we3/wa3/wd3) between two writeback sources. Source 0 is the in-order pipeline writeback. Source 1 is a long-latency unit, such as a load or multiply/divide return.
Fixed priority with a starvation guard decides which source wins. The block registers the winning write onto the port and keeps a scoreboard of destination registers claimed by source 1 that are not yet written. Hazard logic uses that scoreboard to stall readers.

---
 rtl/rf_wb_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_arbiter
// Description : Sequences the single register-file write port (we3/wa3/wd3)
//               between two writeback sources:
//                 source 0 - in-order pipeline writeback
//                 source 1 - long-latency unit (load / mul / div return)
//               Contention is resolved by fixed priority (source 0 first)
//               with a starvation guard. Alternatively it can be resolved
//               round-robin when the RF_WB_RR_EN macro is defined.
//               The winning write is registered onto the port (1-cycle
//               latency). A scoreboard (busy_mask) tracks registers claimed
//               by source 1 that have not yet been written back, so hazard
//               logic can stall readers.
//
// Parameters  : XLEN       - write data width
//               AW         - register address width (2^AW registers)
//               STARVE_MAX - refusals tolerated before source 1 is forced
//                            ahead of source 0 (<= 3)
//
// Ports       : clk, reset                 - clock, sync active-high reset
//               req0_valid/addr/data/ready - source 0 write handshake
//               req1_valid/addr/data/ready - source 1 write handshake
//               claim_valid/claim_addr     - source 1 destination claim
//               we3/wa3/wd3                - registered RF write port
//               busy_mask                  - registered scoreboard
//               starve_cnt                 - starvation counter (debug)
//
// Config      : `define RF_WB_RR_EN selects round-robin arbitration
//               (starve_cnt is then tied to 0).
//
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter #(
    parameter int XLEN       = 32,
    parameter int AW         = 5,
    parameter int STARVE_MAX = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    // source 0: in-order pipeline writeback
    input  logic                 req0_valid,
    input  logic [AW-1:0]        req0_addr,
    input  logic [XLEN-1:0]      req0_data,
    output logic                 req0_ready,
    // source 1: long-latency unit writeback
    input  logic                 req1_valid,
    input  logic [AW-1:0]        req1_addr,
    input  logic [XLEN-1:0]      req1_data,
    output logic                 req1_ready,
    // source 1 destination claims
    input  logic                 claim_valid,
    input  logic [AW-1:0]        claim_addr,
    // register-file write port
    output logic                 we3,
    output logic [AW-1:0]        wa3,
    output logic [XLEN-1:0]      wd3,
    // scoreboard / debug
    output logic [(1<<AW)-1:0]   busy_mask,
    output logic [1:0]           starve_cnt
);

    localparam int         c_NREG       = 1 << AW;
    localparam logic [1:0] c_STARVE_MAX = 2'(STARVE_MAX);

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic              w_grant0;
    logic              w_grant1;
    logic              w_accept;
    logic [AW-1:0]     w_acc_addr;
    logic [XLEN-1:0]   w_acc_data;

`ifdef RF_WB_RR_EN
    // Last winner: 0 = source 0, 1 = source 1. On contention the other
    // source wins, so with both valid from reset source 1 goes first.
    logic r_last_grant;
`else
    logic [1:0] r_starve_cnt;
`endif

    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        // Both readies are held low while reset is asserted so that nothing
        // is handshaken in a cycle whose result would be discarded anyway.
        if (!reset) begin
            if (req0_valid && req1_valid) begin
`ifdef RF_WB_RR_EN
                w_grant1 = ~r_last_grant;
                w_grant0 =  r_last_grant;
`else
                w_grant1 = (r_starve_cnt == c_STARVE_MAX);
                w_grant0 = ~w_grant1;
`endif
            end else begin
                w_grant0 = req0_valid;
                w_grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    // A grant is only ever given to a valid source, so grant == accept.
    assign w_accept   = w_grant0 | w_grant1;
    assign w_acc_addr = w_grant1 ? req1_addr : req0_addr;
    assign w_acc_data = w_grant1 ? req1_data : req0_data;

`ifdef RF_WB_RR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= 1'b0;
        end else if (w_accept) begin
            r_last_grant <= w_grant1;
        end
    end

    assign starve_cnt = 2'b00;
`else
    // Counts consecutive cycles in which source 1 is valid but refused.
    // Any cycle where source 1 is idle or accepted restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= 2'b00;
        end else if (req1_valid && !w_grant1) begin
            if (r_starve_cnt != c_STARVE_MAX) begin
                r_starve_cnt <= r_starve_cnt + 2'b01;
            end
        end else begin
            r_starve_cnt <= 2'b00;
        end
    end

    assign starve_cnt = r_starve_cnt;
`endif

    // ------------------------------------------------------------------
    // Registered write port
    // ------------------------------------------------------------------
    logic              r_we3;
    logic [AW-1:0]     r_wa3;
    logic [XLEN-1:0]   r_wd3;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_we3 <= 1'b0;
            r_wa3 <= '0;
            r_wd3 <= '0;
        end else if (w_accept) begin
            // x0 is hard-wired zero: the handshake completes and the
            // address/data are still captured, but no write is enabled.
            r_we3 <= (w_acc_addr != '0);
            r_wa3 <= w_acc_addr;
            r_wd3 <= w_acc_data;
        end else begin
            r_we3 <= 1'b0;
        end
    end

    assign we3 = r_we3;
    assign wa3 = r_wa3;
    assign wd3 = r_wd3;

    // ------------------------------------------------------------------
    // Scoreboard of source-1 destinations not yet written
    // ------------------------------------------------------------------
    logic [c_NREG-1:0] w_set;
    logic [c_NREG-1:0] w_clr;
    logic [c_NREG-1:0] w_busy_next;
    logic [c_NREG-1:0] r_busy;

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (claim_valid) begin
            w_set[claim_addr] = 1'b1;
        end
        if (w_grant1) begin
            w_clr[req1_addr] = 1'b1;
        end
        // Clear first, then set: a claim arriving in the same cycle as the
        // writeback of the same register belongs to a younger op and wins.
        w_busy_next = (r_busy & ~w_clr) | w_set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            // Bit 0 (x0) can never be busy; claims to it are dropped here.
            r_busy <= {w_busy_next[c_NREG-1:1], 1'b0};
        end
    end

    assign busy_mask = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_wb_arbiter
// Description : Directed self-checking bench for rf_wb_arbiter with the
//               default parameters (XLEN=32, AW=5, STARVE_MAX=3).
//               Inputs change 1 time unit after a rising edge; ready outputs
//               are sampled 1 unit after that, registered outputs are
//               sampled 1 unit after the next rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_wb_arbiter;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic              clk;
    logic              reset;
    logic              req0_valid;
    logic [AW-1:0]     req0_addr;
    logic [XLEN-1:0]   req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [AW-1:0]     req1_addr;
    logic [XLEN-1:0]   req1_data;
    logic              req1_ready;
    logic              claim_valid;
    logic [AW-1:0]     claim_addr;
    logic              we3;
    logic [AW-1:0]     wa3;
    logic [XLEN-1:0]   wd3;
    logic [31:0]       busy_mask;
    logic [1:0]        starve_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    rf_wb_arbiter #(.XLEN(XLEN), .AW(AW), .STARVE_MAX(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_addr   (req0_addr),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_addr   (req1_addr),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .claim_valid (claim_valid),
        .claim_addr  (claim_addr),
        .we3         (we3),
        .wa3         (wa3),
        .wd3         (wd3),
        .busy_mask   (busy_mask),
        .starve_cnt  (starve_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid  = 1'b0;
        req1_valid  = 1'b0;
        claim_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'h11;
        req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'h22;
        claim_valid = 1'b1; claim_addr = 5'd3;
        #1;
        n_cmp++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready0: got %b expected 0", req0_ready); end
        n_cmp++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready1: got %b expected 0", req1_ready); end
        tick(); tick();
        n_cmp++; if (we3 !== 1'b0) begin n_fail++; $display("FAIL reset_we3: got %b expected 0", we3); end
        n_cmp++; if (wa3 !== 5'd0) begin n_fail++; $display("FAIL reset_wa3: got %h expected 0", wa3); end
        n_cmp++; if (wd3 !== 32'h0) begin n_fail++; $display("FAIL reset_wd3: got %h expected 0", wd3); end
        n_cmp++; if (busy_mask !== 32'h0) begin n_fail++; $display("FAIL reset_busy: got %h expected 0", busy_mask); end
        n_cmp++; if (starve_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_starve: got %0d expected 0", starve_cnt); end
        reset = 1'b0;
        idle_inputs();
        tick();
    endtask

    task automatic test_single_write();
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
        #1;
        n_cmp++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready0: got %b expected 1", req0_ready); end
        n_cmp++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready1: got %b expected 0", req1_ready); end
        tick();
        req0_valid = 1'b0;
        n_cmp++; if (we3 !== 1'b1) begin n_fail++; $display("FAIL single_we3: got %b expected 1", we3); end
        n_cmp++; if (wa3 !== 5'd5) begin n_fail++; $display("FAIL single_wa3: got %0d expected 5", wa3); end
        n_cmp++; if (wd3 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_wd3: got %h expected deadbeef", wd3); end
        tick();
        n_cmp++; if (we3 !== 1'b0) begin n_fail++; $display("FAIL idle_we3: got %b expected 0", we3); end
        n_cmp++; if (wa3 !== 5'd5) begin n_fail++; $display("FAIL idle_hold_wa3: got %0d expected 5", wa3); end
        n_cmp++; if (wd3 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL idle_hold_wd3: got %h expected deadbeef", wd3); end
    endtask

    task automatic test_x0_drop();
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h1234;
        #1;
        n_cmp++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready1: got %b expected 1", req1_ready); end
        tick();
        req1_valid = 1'b0;
        n_cmp++; if (we3 !== 1'b0) begin n_fail++; $display("FAIL x0_we3: got %b expected 0", we3); end
        n_cmp++; if (wa3 !== 5'd0) begin n_fail++; $display("FAIL x0_wa3: got %0d expected 0", wa3); end
        n_cmp++; if (wd3 !== 32'h1234) begin n_fail++; $display("FAIL x0_wd3: got %h expected 1234", wd3); end
        tick();
    endtask

    task automatic test_back_to_back();
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h33;
        tick();
        req0_addr = 5'd4; req0_data = 32'h44;
        n_cmp++; if ({we3, wa3, wd3} !== {1'b1, 5'd3, 32'h33}) begin n_fail++; $display("FAIL b2b_first: got %b/%0d/%h expected 1/3/33", we3, wa3, wd3); end
        tick();
        req0_valid = 1'b0;
        n_cmp++; if ({we3, wa3, wd3} !== {1'b1, 5'd4, 32'h44}) begin n_fail++; $display("FAIL b2b_second: got %b/%0d/%h expected 1/4/44", we3, wa3, wd3); end
        tick();
    endtask

`ifdef RF_WB_RR_EN
    task automatic test_contention();
        req0_valid = 1'b1; req0_addr = 5'd1; req1_valid = 1'b1; req1_addr = 5'd2;
        for (int c = 0; c < 4; c++) begin
            logic exp_g1;
            exp_g1 = ((c % 2) == 0);
            req0_data = 32'hA0 + 32'(c); req1_data = 32'hB0 + 32'(c);
            #1;
            n_cmp++; if ({req1_ready, req0_ready} !== {exp_g1, ~exp_g1}) begin n_fail++; $display("FAIL rr_grant c%0d: got r1=%b r0=%b expected r1=%b", c, req1_ready, req0_ready, exp_g1); end
            n_cmp++; if (starve_cnt !== 2'd0) begin n_fail++; $display("FAIL rr_starve c%0d: got %0d expected 0", c, starve_cnt); end
            tick();
        end
        idle_inputs();
        tick();
    endtask
`else
    task automatic test_contention();
        req0_valid = 1'b1; req0_addr = 5'd1; req1_valid = 1'b1; req1_addr = 5'd2;
        for (int c = 0; c < 8; c++) begin
            logic       exp_g1;
            logic [1:0] exp_cnt;
            exp_g1  = (c == 3) || (c == 7);
            exp_cnt = 2'(c % 4);
            req0_data = 32'hA0 + 32'(c); req1_data = 32'hB0 + 32'(c);
            #1;
            n_cmp++; if (starve_cnt !== exp_cnt) begin n_fail++; $display("FAIL starve_cnt c%0d: got %0d expected %0d", c, starve_cnt, exp_cnt); end
            n_cmp++; if ({req1_ready, req0_ready} !== {exp_g1, ~exp_g1}) begin n_fail++; $display("FAIL starve_grant c%0d: got r1=%b r0=%b expected r1=%b", c, req1_ready, req0_ready, exp_g1); end
            tick();
            n_cmp++; if (wd3 !== (exp_g1 ? 32'hB0 + 32'(c) : 32'hA0 + 32'(c))) begin n_fail++; $display("FAIL starve_wd3 c%0d: got %h expected %h", c, wd3, exp_g1 ? 32'hB0 + 32'(c) : 32'hA0 + 32'(c)); end
        end
        idle_inputs();
        tick();
        n_cmp++; if (starve_cnt !== 2'd0) begin n_fail++; $display("FAIL starve_end: got %0d expected 0", starve_cnt); end
    endtask
`endif

    task automatic test_scoreboard();
        claim_valid = 1'b1; claim_addr = 5'd7;
        tick();
        claim_valid = 1'b0;
        n_cmp++; if (busy_mask !== 32'h0000_0080) begin n_fail++; $display("FAIL sb_claim7: got %h expected 00000080", busy_mask); end
        // same-cycle claim and writeback of r7: the claim survives
        claim_valid = 1'b1; claim_addr = 5'd7;
        req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h77;
        #1;
        n_cmp++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL sb_ready1: got %b expected 1", req1_ready); end
        tick();
        idle_inputs();
        n_cmp++; if (busy_mask !== 32'h0000_0080) begin n_fail++; $display("FAIL sb_set_wins: got %h expected 00000080", busy_mask); end
        n_cmp++; if ({we3, wa3} !== {1'b1, 5'd7}) begin n_fail++; $display("FAIL sb_write7: got %b/%0d expected 1/7", we3, wa3); end
        req1_valid = 1'b1; req1_addr = 5'd7;
        tick();
        req1_valid = 1'b0;
        n_cmp++; if (busy_mask !== 32'h0) begin n_fail++; $display("FAIL sb_clear7: got %h expected 0", busy_mask); end
        // x0 claim ignored; source-0 write never clears a busy bit
        claim_valid = 1'b1; claim_addr = 5'd0;
        tick();
        claim_addr = 5'd10;
        n_cmp++; if (busy_mask !== 32'h0) begin n_fail++; $display("FAIL sb_claim_x0: got %h expected 0", busy_mask); end
        tick();
        claim_valid = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd10; req0_data = 32'hAA;
        tick();
        req0_valid = 1'b0;
        n_cmp++; if (busy_mask !== 32'h0000_0400) begin n_fail++; $display("FAIL sb_src0_noclr: got %h expected 00000400", busy_mask); end
        // clearing a register that is not busy is a no-op
        req1_valid = 1'b1; req1_addr = 5'd12;
        tick();
        req1_valid = 1'b0;
        n_cmp++; if (busy_mask !== 32'h0000_0400) begin n_fail++; $display("FAIL sb_clr_nonbusy: got %h expected 00000400", busy_mask); end
    endtask

    task automatic test_reset_midstream();
        // bit 10 is still busy from the scoreboard test; add bit 7
        claim_valid = 1'b1; claim_addr = 5'd7;
        tick();
        claim_valid = 1'b0;
        n_cmp++; if (busy_mask !== 32'h0000_0480) begin n_fail++; $display("FAIL mid_busy: got %h expected 00000480", busy_mask); end
        // accept offered in the same cycle reset pulses: must be dropped
        reset = 1'b1;
        req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h99;
        #1;
        n_cmp++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready0: got %b expected 0", req0_ready); end
        tick();
        reset = 1'b0;
        req0_valid = 1'b0;
        n_cmp++; if (we3 !== 1'b0) begin n_fail++; $display("FAIL mid_we3: got %b expected 0", we3); end
        n_cmp++; if (busy_mask !== 32'h0) begin n_fail++; $display("FAIL mid_busy_clr: got %h expected 0", busy_mask); end
        n_cmp++; if (wa3 !== 5'd0) begin n_fail++; $display("FAIL mid_wa3: got %0d expected 0", wa3); end
        tick();
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        claim_valid = 1'b0; claim_addr = '0;
        test_reset();
        test_single_write();
        test_x0_drop();
        test_back_to_back();
        test_contention();
        test_scoreboard();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
